// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Covers operation decode, FSM states, iteration count and special-case results.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned ITERATIONS = 32;
  localparam int unsigned CNT_WIDTH  = $clog2(ITERATIONS);

  localparam logic [31:0] DIV_ZERO_QUOTIENT  = 32'hFFFF_FFFF;
  localparam logic [31:0] OVERFLOW_QUOTIENT  = 32'h8000_0000;
  localparam logic [31:0] OVERFLOW_REMAINDER = 32'h0000_0000;

  function automatic logic is_signed_a(input op_e op);
    return (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic is_signed_b(input op_e op);
    return (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic is_div_op(input op_e op);
    return (op == OpDiv) || (op == OpDivu) || (op == OpRem) || (op == OpRemu);
  endfunction

  function automatic logic is_rem_op(input op_e op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration on the shared 2W-bit accumulator: shift-add for
// multiply, restoring compare-subtract-shift for divide.
module muldiv_step #(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                    is_div_i,
  input  logic [2*WORD_WIDTH-1:0] acc_i,
  input  logic [WORD_WIDTH-1:0]   operand_i,
  output logic [2*WORD_WIDTH-1:0] acc_o
);

  localparam int unsigned W = WORD_WIDTH;

  logic [W:0] mul_sum;
  logic [W:0] div_shift;
  logic [W:0] div_diff;

  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, high half the partial sum.
    mul_sum   = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    // Divide: high half is the partial remainder, low half shifts the dividend out
    // and the quotient bits in.
    div_shift = {acc_i[2*W-1:W], acc_i[W-1]};
    div_diff  = div_shift - {1'b0, operand_i};

    if (!is_div_i) begin
      acc_o = {mul_sum, acc_i[W-1:1]};
    end else if (!div_diff[W]) begin
      acc_o = {div_diff[W-1:0], acc_i[W-2:0], 1'b1};
    end else begin
      acc_o = {div_shift[W-1:0], acc_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit writing its result to a register-file port.
// Operates on operand magnitudes and applies the sign correction on completion.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [WORD_WIDTH-1:0]    rs1_val,
  input  logic [WORD_WIDTH-1:0]    rs2_val,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     busy,
  output logic                     done,
  output logic [WORD_WIDTH-1:0]    wd,
  output logic [ADDRESS_WIDTH-1:0] wa,
  output logic                     wen
);

  localparam int unsigned W = WORD_WIDTH;

  state_e                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  op_e                      op_q, op_d;
  logic [W-1:0]             opnd_q, opnd_d;
  logic [2*W-1:0]           acc_q, acc_d;
  logic                     neg_q, neg_d;
  logic                     special_q, special_d;
  logic [W-1:0]             wd_q, wd_d;
  logic [ADDRESS_WIDTH-1:0] wa_q, wa_d;

  op_e          op_in;
  logic         sign_a, sign_b;
  logic [W-1:0] mag_a, mag_b;
  logic         div_zero, overflow;
  logic [W-1:0] special_res;

  always_comb begin
    op_in       = op_e'(op);
    sign_a      = is_signed_a(op_in) & rs1_val[W-1];
    sign_b      = is_signed_b(op_in) & rs2_val[W-1];
    mag_a       = sign_a ? (~rs1_val + 1'b1) : rs1_val;
    mag_b       = sign_b ? (~rs2_val + 1'b1) : rs2_val;
    div_zero    = is_div_op(op_in) && (rs2_val == '0);
    overflow    = ((op_in == OpDiv) || (op_in == OpRem)) &&
                  (rs1_val == OVERFLOW_QUOTIENT) && (rs2_val == '1);
    special_res = OVERFLOW_QUOTIENT;
    if (div_zero) begin
      special_res = is_rem_op(op_in) ? rs1_val : DIV_ZERO_QUOTIENT;
    end else if (is_rem_op(op_in)) begin
      special_res = OVERFLOW_REMAINDER;
    end
  end

  logic [2*W-1:0] step_acc;

  muldiv_step #(
    .WORD_WIDTH(W)
  ) u_step (
    .is_div_i (is_div_op(op_q)),
    .acc_i    (acc_q),
    .operand_i(opnd_q),
    .acc_o    (step_acc)
  );

  // Result of the final iteration, sign-corrected, ready to be captured into wd.
  logic [2*W-1:0] prod;
  logic [W-1:0]   div_raw;
  logic [W-1:0]   result;

  always_comb begin
    prod    = neg_q ? (~step_acc + 1'b1) : step_acc;
    div_raw = is_rem_op(op_q) ? step_acc[2*W-1:W] : step_acc[W-1:0];
    if (is_div_op(op_q)) begin
      result = neg_q ? (~div_raw + 1'b1) : div_raw;
    end else if (op_q == OpMul) begin
      result = prod[W-1:0];
    end else begin
      result = prod[2*W-1:W];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    special_d = special_q;
    wd_d      = wd_q;
    wa_d      = wa_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StCalc;
          cnt_d     = '0;
          op_d      = op_in;
          wa_d      = rd_addr;
          neg_d     = (op_in == OpRem) ? sign_a : (sign_a ^ sign_b);
          special_d = div_zero | overflow;
          opnd_d    = is_div_op(op_in) ? mag_b : mag_a;
          if (div_zero | overflow) begin
            acc_d = {{W{1'b0}}, special_res};
          end else begin
            acc_d = {{W{1'b0}}, (is_div_op(op_in) ? mag_a : mag_b)};
          end
        end
      end
      StCalc: begin
        if (special_q) begin
          state_d = StDone;
          wd_d    = acc_q[W-1:0];
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_WIDTH'(ITERATIONS - 1)) begin
            state_d = StDone;
            wd_d    = result;
          end
        end
      end
      StDone: begin
        state_d   = StIdle;
        special_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= OpMul;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      wd_q      <= '0;
      wa_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      wd_q      <= wd_d;
      wa_q      <= wa_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign wd   = wd_q;
  assign wa   = wa_q;
  assign wen  = done && (wa_q != '0);

endmodule
